id_pipe: RTL and testbench
==========================

Name: id_pipe

Overview:
- Parametrised, registered instruction-decode stage. Successor to the combinational decoder.
- Sits between the fetch stage and the execute stage. Decodes RV32I/RV64I opcodes and reads the register file.
- Forwards results from EX and MEM, detects load-use hazards and inserts bubbles.
- Holds a multi-cycle control-flow pause and drives a valid/ready-registered ID/EX output.

Parameters:
- XLEN, 32, datapath width (32 or 64); immediates sign-extend to XLEN.
- REG_AW, 5, register address width.
- PAUSE_CYCLES, 2, cycles in_ready stays low after accepting a branch/JAL/JALR (1..15).
- FWD_EN, 1, 1 = EX/MEM forwarding enabled; 0 = regfile data only, and any RAW hazard on EX or MEM stalls.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  fetch presents inst
- in_ready  out  1  stage accepts inst this cycle
- inst  in  32  instruction word
- inst_addr  in  XLEN  instruction address
- regs_addr1  out  REG_AW  regfile read port 1 address (combinational)
- regs_data1  in  XLEN  regfile read port 1 data (same cycle)
- regs_addr2  out  REG_AW  regfile read port 2 address
- regs_data2  in  XLEN  regfile read port 2 data
- ex_wb_en  in  1  EX instruction writes rd
- ex_rd  in  REG_AW  EX destination
- ex_data  in  XLEN  EX result
- ex_is_load  in  1  EX instruction is a load (data not yet available)
- mem_wb_en  in  1  MEM instruction writes rd
- mem_rd  in  REG_AW  MEM destination
- mem_data  in  XLEN  MEM result
- flush  in  1  kill in-flight decode (branch resolved taken/redirect)
- out_valid  out  1  ID/EX register holds a valid instruction
- out_ready  in  1  EX accepts
- out_inst  out  32  registered instruction
- out_inst_addr  out  XLEN  registered address
- out_operand1  out  XLEN  registered operand 1
- out_operand2  out  XLEN  registered operand 2
- out_rd  out  REG_AW  registered destination (0 if none)
- out_is_load  out  1  registered load flag
- pause_signal  out  1  control-flow pause active

Behaviour:
- Reset (clk edge with rst=1): out_valid=0, out_inst=0x00000013 (NOP), out_inst_addr=0, operands=0, out_rd=0, out_is_load=0, pause counter=0, pause_signal=0.
- Operand select per opcode:
  - R, S, B: rs1/rs2 values.
  - I-ALU, LOAD, JALR: rs1 value, sign-extended imm_i.
  - LUI: 0, {imm_u, 12'b0} sign-extended (new: operand1=0, not PC).
  - AUIPC: PC, same immediate.
  - JAL: PC, sign-extended {imm_j, 0}.
  - SYSTEM / unknown opcode: operands 0, no regs read, out_rd=0.
- rd is captured only for opcodes that write rd (R, I-ALU, LOAD, JALR, JAL, LUI, AUIPC); else 0.
- regs_addrN = rsN when the opcode uses that source, else 0.
- Source value priority per operand: x0 -> 0. Otherwise EX match (ex_wb_en, ex_rd==rs, !ex_is_load), then MEM match, then regs_dataN.
- Load-use hazard: ex_wb_en && ex_is_load && ex_rd!=0 && ex_rd equals a used rs.
  - in_ready=0.
  - On the next output advance, load a bubble (out_valid=0, NOP).
  - Re-evaluates each cycle; resolves when the load moves to MEM.
- With FWD_EN=0, any EX/MEM match on a used rs is treated as a hazard.
- Output advance condition: adv = !out_valid || out_ready.
  - in_ready = adv && !hazard && pause_cnt==0 && !flush.
  - Accept when in_valid && in_ready: register decoded fields, out_valid=1.
  - When adv but nothing accepted: out_valid=0.
  - When !adv: hold all outputs.
- Latency: 1 cycle from accept to out_valid.
- Pause: accepting B/JAL/JALR loads pause_cnt=PAUSE_CYCLES. Decrement by 1 each cycle while nonzero. pause_signal = (pause_cnt!=0).
- Flush (highest priority, same cycle):
  - in_ready=0; nothing accepted.
  - Next edge: out_valid=0, pause_cnt=0.
  - Flush with out_ready=0 still kills the output.
- Simultaneous hazard + pause: both block; pause_cnt still counts down.
- rst during stall or pause: reset values win; first accept is possible on the cycle after rst deasserts.

Test Plan:
- ADDI x1,x0,-5 (0xFFB00093), PC=0x100, out_ready=1 -> next cycle out_valid=1, operand1=0, operand2=0xFFFFFFFB, out_rd=1.
- ADD x3,x1,x2; EX writes x1=0x11, MEM writes x2=0x22, regfile stale -> operand1=0x11, operand2=0x22. Same with ex_rd=mem_rd=1 -> EX value wins. rs1=x0 with ex_rd=0 -> operand1=0.
- LW x5 in EX (ex_is_load=1, ex_rd=5) while decoding ADD x6,x5,x5 -> in_ready=0 for 1 cycle, one bubble (out_valid=0), then ADD issues with MEM-forwarded value.
- JAL x1,+8 at PC=0x200, PAUSE_CYCLES=2 -> operand1=0x200, operand2=8, pause_signal high 2 cycles, in_ready low 2 cycles.
- out_ready=0 for 3 cycles with valid output -> outputs held stable, in_ready=0. Assert flush in cycle 2 -> out_valid=0 next edge, pause cleared.
- XLEN=64: LUI x7,0x80000 -> operand1=0, operand2=0xFFFFFFFF80000000. rst mid-pause -> pause_signal=0 next edge.

Source files
------------

// File: rtl/id_pipe_if.sv
// Fetch-to-decode and ID/EX valid/ready bus of the id_pipe decode stage.
// slave is the decode stage's view; master is the surrounding pipeline's view.
interface id_pipe_if #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
);
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       inst;
    logic [XLEN-1:0]   inst_addr;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_inst;
    logic [XLEN-1:0]   out_inst_addr;
    logic [XLEN-1:0]   out_operand1;
    logic [XLEN-1:0]   out_operand2;
    logic [REG_AW-1:0] out_rd;
    logic              out_is_load;

    modport slave (
        input  in_valid, inst, inst_addr, out_ready,
        output in_ready, out_valid, out_inst, out_inst_addr,
               out_operand1, out_operand2, out_rd, out_is_load
    );

    modport master (
        output in_valid, inst, inst_addr, out_ready,
        input  in_ready, out_valid, out_inst, out_inst_addr,
               out_operand1, out_operand2, out_rd, out_is_load
    );
endinterface

// File: rtl/id_pipe.sv
// Registered RV32I/RV64I decode stage: operand selection with EX/MEM forwarding,
// load-use stalls, post-control-flow pause and a valid/ready ID/EX register.
module id_pipe #(
    parameter int XLEN         = 32,
    parameter int REG_AW       = 5,
    parameter int PAUSE_CYCLES = 2,
    parameter bit FWD_EN       = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    id_pipe_if.slave          bus,
    output logic [REG_AW-1:0] regs_addr1,
    input  logic [XLEN-1:0]   regs_data1,
    output logic [REG_AW-1:0] regs_addr2,
    input  logic [XLEN-1:0]   regs_data2,
    input  logic              ex_wb_en,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic [XLEN-1:0]   ex_data,
    input  logic              ex_is_load,
    input  logic              mem_wb_en,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic [XLEN-1:0]   mem_data,
    input  logic              flush,
    output logic              pause_signal
);
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM32 = 7'b0011011;
    localparam logic [6:0] OPC_OP32   = 7'b0111011;

    localparam logic [1:0] OP1_ZERO = 2'd0;
    localparam logic [1:0] OP1_SRC  = 2'd1;
    localparam logic [1:0] OP1_PC   = 2'd2;
    localparam logic [1:0] OP2_ZERO = 2'd0;
    localparam logic [1:0] OP2_SRC  = 2'd1;
    localparam logic [1:0] OP2_IMM  = 2'd2;

    localparam logic [31:0] NOP        = 32'h0000_0013;
    localparam logic [3:0]  PAUSE_INIT = 4'(PAUSE_CYCLES);

    logic              out_valid_reg;
    logic [31:0]       out_inst_reg;
    logic [XLEN-1:0]   out_inst_addr_reg;
    logic [XLEN-1:0]   out_operand1_reg;
    logic [XLEN-1:0]   out_operand2_reg;
    logic [REG_AW-1:0] out_rd_reg;
    logic              out_is_load_reg;
    logic [3:0]        pause_cnt_reg;

    logic [6:0]        opcode;
    logic [XLEN-1:0]   imm_i;
    logic [XLEN-1:0]   imm_u;
    logic [XLEN-1:0]   imm_j;
    logic [XLEN-1:0]   imm_next;
    logic [1:0]        use_rs;
    logic              writes_rd;
    logic              is_ctrl;
    logic              is_load_next;
    logic [1:0]        op1_mode;
    logic [1:0]        op2_mode;
    logic [XLEN-1:0]   op1_next;
    logic [XLEN-1:0]   op2_next;
    logic [REG_AW-1:0] rd_next;

    logic [REG_AW-1:0] src_rs    [2];
    logic [XLEN-1:0]   src_rdata [2];
    logic [XLEN-1:0]   src_val   [2];
    logic [1:0]        src_haz;

    logic hazard;
    logic adv;
    logic in_ready_int;
    logic accept;

    assign opcode = bus.inst[6:0];
    assign imm_i  = XLEN'($signed(bus.inst[31:20]));
    assign imm_u  = XLEN'($signed({bus.inst[31:12], 12'b0}));
    assign imm_j  = XLEN'($signed({bus.inst[31], bus.inst[19:12], bus.inst[20],
                                   bus.inst[30:21], 1'b0}));

    always_comb begin
        use_rs       = 2'b00;
        writes_rd    = 1'b0;
        is_ctrl      = 1'b0;
        is_load_next = 1'b0;
        op1_mode     = OP1_ZERO;
        op2_mode     = OP2_ZERO;
        imm_next     = '0;
        case (opcode)
            OPC_OP: begin
                use_rs = 2'b11; writes_rd = 1'b1;
                op1_mode = OP1_SRC; op2_mode = OP2_SRC;
            end
            OPC_OP32: begin
                if (XLEN == 64) begin
                    use_rs = 2'b11; writes_rd = 1'b1;
                    op1_mode = OP1_SRC; op2_mode = OP2_SRC;
                end
            end
            OPC_OPIMM: begin
                use_rs = 2'b01; writes_rd = 1'b1;
                op1_mode = OP1_SRC; op2_mode = OP2_IMM; imm_next = imm_i;
            end
            OPC_OPIMM32: begin
                if (XLEN == 64) begin
                    use_rs = 2'b01; writes_rd = 1'b1;
                    op1_mode = OP1_SRC; op2_mode = OP2_IMM; imm_next = imm_i;
                end
            end
            OPC_LOAD: begin
                use_rs = 2'b01; writes_rd = 1'b1; is_load_next = 1'b1;
                op1_mode = OP1_SRC; op2_mode = OP2_IMM; imm_next = imm_i;
            end
            OPC_JALR: begin
                use_rs = 2'b01; writes_rd = 1'b1; is_ctrl = 1'b1;
                op1_mode = OP1_SRC; op2_mode = OP2_IMM; imm_next = imm_i;
            end
            OPC_STORE: begin
                use_rs = 2'b11;
                op1_mode = OP1_SRC; op2_mode = OP2_SRC;
            end
            OPC_BRANCH: begin
                use_rs = 2'b11; is_ctrl = 1'b1;
                op1_mode = OP1_SRC; op2_mode = OP2_SRC;
            end
            OPC_LUI: begin
                writes_rd = 1'b1;
                op1_mode = OP1_ZERO; op2_mode = OP2_IMM; imm_next = imm_u;
            end
            OPC_AUIPC: begin
                writes_rd = 1'b1;
                op1_mode = OP1_PC; op2_mode = OP2_IMM; imm_next = imm_u;
            end
            OPC_JAL: begin
                writes_rd = 1'b1; is_ctrl = 1'b1;
                op1_mode = OP1_PC; op2_mode = OP2_IMM; imm_next = imm_j;
            end
            default: ;
        endcase
    end

    assign src_rs[0]    = REG_AW'(bus.inst[19:15]);
    assign src_rs[1]    = REG_AW'(bus.inst[24:20]);
    assign src_rdata[0] = regs_data1;
    assign src_rdata[1] = regs_data2;

    // A load still in EX has no data yet, so it never forwards; it stalls instead.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_src
            logic ex_hit;
            logic mem_hit;
            assign ex_hit  = ex_wb_en  && (ex_rd  == src_rs[gi]);
            assign mem_hit = mem_wb_en && (mem_rd == src_rs[gi]);
            assign src_val[gi] = (src_rs[gi] == '0)                    ? '0       :
                                 (FWD_EN && ex_hit && !ex_is_load)     ? ex_data  :
                                 (FWD_EN && mem_hit)                   ? mem_data :
                                                                         src_rdata[gi];
            assign src_haz[gi] = use_rs[gi] && (src_rs[gi] != '0) &&
                                 ((ex_hit && ex_is_load) || (!FWD_EN && (ex_hit || mem_hit)));
        end
    endgenerate

    assign regs_addr1 = use_rs[0] ? src_rs[0] : '0;
    assign regs_addr2 = use_rs[1] ? src_rs[1] : '0;

    always_comb begin
        op1_next = '0;
        op2_next = '0;
        case (op1_mode)
            OP1_SRC: op1_next = src_val[0];
            OP1_PC:  op1_next = bus.inst_addr;
            default: op1_next = '0;
        endcase
        case (op2_mode)
            OP2_SRC: op2_next = src_val[1];
            OP2_IMM: op2_next = imm_next;
            default: op2_next = '0;
        endcase
    end

    assign rd_next      = writes_rd ? REG_AW'(bus.inst[11:7]) : '0;
    assign hazard       = |src_haz;
    assign adv          = !out_valid_reg || bus.out_ready;
    assign in_ready_int = adv && !hazard && (pause_cnt_reg == 4'd0) && !flush;
    assign accept       = bus.in_valid && in_ready_int;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_reg     <= 1'b0;
            out_inst_reg      <= NOP;
            out_inst_addr_reg <= '0;
            out_operand1_reg  <= '0;
            out_operand2_reg  <= '0;
            out_rd_reg        <= '0;
            out_is_load_reg   <= 1'b0;
            pause_cnt_reg     <= 4'd0;
        end else begin
            if (flush)
                pause_cnt_reg <= 4'd0;
            else if (accept && is_ctrl)
                pause_cnt_reg <= PAUSE_INIT;
            else if (pause_cnt_reg != 4'd0)
                pause_cnt_reg <= pause_cnt_reg - 4'd1;

            // Flush kills the output even when EX is not accepting.
            if (accept) begin
                out_valid_reg     <= 1'b1;
                out_inst_reg      <= bus.inst;
                out_inst_addr_reg <= bus.inst_addr;
                out_operand1_reg  <= op1_next;
                out_operand2_reg  <= op2_next;
                out_rd_reg        <= rd_next;
                out_is_load_reg   <= is_load_next;
            end else if (adv || flush) begin
                out_valid_reg     <= 1'b0;
                out_inst_reg      <= NOP;
                out_inst_addr_reg <= '0;
                out_operand1_reg  <= '0;
                out_operand2_reg  <= '0;
                out_rd_reg        <= '0;
                out_is_load_reg   <= 1'b0;
            end
        end
    end

    assign bus.in_ready      = in_ready_int;
    assign bus.out_valid     = out_valid_reg;
    assign bus.out_inst      = out_inst_reg;
    assign bus.out_inst_addr = out_inst_addr_reg;
    assign bus.out_operand1  = out_operand1_reg;
    assign bus.out_operand2  = out_operand2_reg;
    assign bus.out_rd        = out_rd_reg;
    assign bus.out_is_load   = out_is_load_reg;
    assign pause_signal      = (pause_cnt_reg != 4'd0);
endmodule

// File: tb/tb_id_pipe.sv
// Directed bench for id_pipe: a 32-bit forwarding instance and a 64-bit
// no-forwarding instance driven in turn from one initial block.
module tb_id_pipe;
    localparam logic [31:0] I_ADDI  = 32'hFFB0_0093;  // addi x1,x0,-5
    localparam logic [31:0] I_ADD3  = 32'h0020_81B3;  // add  x3,x1,x2
    localparam logic [31:0] I_ADD4  = 32'h0020_0233;  // add  x4,x0,x2
    localparam logic [31:0] I_ADD6  = 32'h0052_8333;  // add  x6,x5,x5
    localparam logic [31:0] I_SW    = 32'h0020_A223;  // sw   x2,4(x1)
    localparam logic [31:0] I_ECALL = 32'h0000_0073;
    localparam logic [31:0] I_JAL   = 32'h0080_00EF;  // jal  x1,+8
    localparam logic [31:0] I_LUI   = 32'h8000_03B7;  // lui  x7,0x80000

    logic clk = 1'b0;
    logic rst_a, rst_b;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    id_pipe_if #(.XLEN(32), .REG_AW(5)) bus_a ();
    id_pipe_if #(.XLEN(64), .REG_AW(5)) bus_b ();

    logic [4:0]  a_addr1, a_addr2, a_ex_rd, a_mem_rd;
    logic [31:0] a_rd1, a_rd2, a_ex_data, a_mem_data;
    logic        a_ex_wb, a_ex_ld, a_mem_wb, a_flush, a_pause;

    logic [4:0]  b_addr1, b_addr2, b_ex_rd, b_mem_rd;
    logic [63:0] b_rd1, b_rd2, b_ex_data, b_mem_data;
    logic        b_ex_wb, b_ex_ld, b_mem_wb, b_flush, b_pause;

    // Stale register file: value encodes its own address.
    assign a_rd1 = 32'hA000_0000 | 32'(a_addr1);
    assign a_rd2 = 32'hA000_0000 | 32'(a_addr2);
    assign b_rd1 = 64'hB000_0000_0000_0000 | 64'(b_addr1);
    assign b_rd2 = 64'hB000_0000_0000_0000 | 64'(b_addr2);

    id_pipe #(.XLEN(32), .REG_AW(5), .PAUSE_CYCLES(2), .FWD_EN(1'b1)) u_a (
        .clk(clk), .rst(rst_a), .bus(bus_a.slave),
        .regs_addr1(a_addr1), .regs_data1(a_rd1),
        .regs_addr2(a_addr2), .regs_data2(a_rd2),
        .ex_wb_en(a_ex_wb), .ex_rd(a_ex_rd), .ex_data(a_ex_data), .ex_is_load(a_ex_ld),
        .mem_wb_en(a_mem_wb), .mem_rd(a_mem_rd), .mem_data(a_mem_data),
        .flush(a_flush), .pause_signal(a_pause)
    );

    id_pipe #(.XLEN(64), .REG_AW(5), .PAUSE_CYCLES(3), .FWD_EN(1'b0)) u_b (
        .clk(clk), .rst(rst_b), .bus(bus_b.slave),
        .regs_addr1(b_addr1), .regs_data1(b_rd1),
        .regs_addr2(b_addr2), .regs_data2(b_rd2),
        .ex_wb_en(b_ex_wb), .ex_rd(b_ex_rd), .ex_data(b_ex_data), .ex_is_load(b_ex_ld),
        .mem_wb_en(b_mem_wb), .mem_rd(b_mem_rd), .mem_data(b_mem_data),
        .flush(b_flush), .pause_signal(b_pause)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_a = 1'b1; rst_b = 1'b1;
        bus_a.in_valid = 1'b0; bus_a.inst = I_ECALL; bus_a.inst_addr = '0; bus_a.out_ready = 1'b1;
        bus_b.in_valid = 1'b0; bus_b.inst = I_ECALL; bus_b.inst_addr = '0; bus_b.out_ready = 1'b1;
        a_ex_wb = 0; a_ex_ld = 0; a_ex_rd = 0; a_ex_data = 0;
        a_mem_wb = 0; a_mem_rd = 0; a_mem_data = 0; a_flush = 0;
        b_ex_wb = 0; b_ex_ld = 0; b_ex_rd = 0; b_ex_data = 0;
        b_mem_wb = 0; b_mem_rd = 0; b_mem_data = 0; b_flush = 0;
        step(); step();

        chk("rst_valid", 64'(bus_a.out_valid), 64'd0);
        chk("rst_inst",  64'(bus_a.out_inst), 64'h13);
        chk("rst_addr",  64'(bus_a.out_inst_addr), 64'd0);
        chk("rst_op1",   64'(bus_a.out_operand1), 64'd0);
        chk("rst_op2",   64'(bus_a.out_operand2), 64'd0);
        chk("rst_rd",    64'(bus_a.out_rd), 64'd0);
        chk("rst_pause", 64'(a_pause), 64'd0);
        rst_a = 1'b0; rst_b = 1'b0;

        // ADDI x1,x0,-5
        bus_a.in_valid = 1'b1; bus_a.inst = I_ADDI; bus_a.inst_addr = 32'h100;
        #1 chk("addi_ready", 64'(bus_a.in_ready), 64'd1);
        step();
        chk("addi_valid", 64'(bus_a.out_valid), 64'd1);
        chk("addi_op1",   64'(bus_a.out_operand1), 64'd0);
        chk("addi_op2",   64'(bus_a.out_operand2), 64'hFFFF_FFFB);
        chk("addi_rd",    64'(bus_a.out_rd), 64'd1);
        chk("addi_pc",    64'(bus_a.out_inst_addr), 64'h100);

        // ADD x3,x1,x2 with EX->x1, MEM->x2
        bus_a.inst = I_ADD3; bus_a.inst_addr = 32'h104;
        a_ex_wb = 1; a_ex_rd = 1; a_ex_data = 32'h11;
        a_mem_wb = 1; a_mem_rd = 2; a_mem_data = 32'h22;
        #1 chk("add_raddr1", 64'(a_addr1), 64'd1);
        chk("add_raddr2", 64'(a_addr2), 64'd2);
        step();
        chk("fwd_ex_op1",  64'(bus_a.out_operand1), 64'h11);
        chk("fwd_mem_op2", 64'(bus_a.out_operand2), 64'h22);
        chk("add_rd",      64'(bus_a.out_rd), 64'd3);

        // EX and MEM both target x1: EX wins, x2 falls back to regfile
        a_mem_rd = 1; a_mem_data = 32'h33;
        step();
        chk("ex_prio_op1", 64'(bus_a.out_operand1), 64'h11);
        chk("rf_op2",      64'(bus_a.out_operand2), 64'hA000_0002);

        // rs1=x0 while EX writes x0
        bus_a.inst = I_ADD4; a_ex_rd = 0; a_ex_data = 32'h55; a_mem_wb = 0;
        step();
        chk("x0_op1", 64'(bus_a.out_operand1), 64'd0);
        chk("x0_op2", 64'(bus_a.out_operand2), 64'hA000_0002);

        // Store: no rd
        bus_a.inst = I_SW; a_ex_wb = 0;
        step();
        chk("sw_op1", 64'(bus_a.out_operand1), 64'hA000_0001);
        chk("sw_op2", 64'(bus_a.out_operand2), 64'hA000_0002);
        chk("sw_rd",  64'(bus_a.out_rd), 64'd0);

        // ECALL: no regs read, zero operands
        bus_a.inst = I_ECALL;
        #1 chk("ecall_raddr1", 64'(a_addr1), 64'd0);
        step();
        chk("ecall_valid", 64'(bus_a.out_valid), 64'd1);
        chk("ecall_op1",   64'(bus_a.out_operand1), 64'd0);
        chk("ecall_rd",    64'(bus_a.out_rd), 64'd0);

        // Load-use: LW x5 in EX, decoding ADD x6,x5,x5
        bus_a.inst = I_ADD6; bus_a.inst_addr = 32'h120;
        a_ex_wb = 1; a_ex_ld = 1; a_ex_rd = 5; a_ex_data = 32'h999;
        #1 chk("lu_ready0", 64'(bus_a.in_ready), 64'd0);
        step();
        chk("lu_bubble_valid", 64'(bus_a.out_valid), 64'd0);
        chk("lu_bubble_inst",  64'(bus_a.out_inst), 64'h13);
        a_ex_wb = 0; a_ex_ld = 0; a_mem_wb = 1; a_mem_rd = 5; a_mem_data = 32'h77;
        #1 chk("lu_ready1", 64'(bus_a.in_ready), 64'd1);
        step();
        chk("lu_valid", 64'(bus_a.out_valid), 64'd1);
        chk("lu_op1",   64'(bus_a.out_operand1), 64'h77);
        chk("lu_op2",   64'(bus_a.out_operand2), 64'h77);
        chk("lu_rd",    64'(bus_a.out_rd), 64'd6);
        a_mem_wb = 0;

        // JAL x1,+8 at 0x200: two pause cycles
        bus_a.inst = I_JAL; bus_a.inst_addr = 32'h200;
        step();
        chk("jal_op1",   64'(bus_a.out_operand1), 64'h200);
        chk("jal_op2",   64'(bus_a.out_operand2), 64'd8);
        chk("jal_rd",    64'(bus_a.out_rd), 64'd1);
        chk("jal_pause1", 64'(a_pause), 64'd1);
        bus_a.inst = I_ADDI; bus_a.inst_addr = 32'h204;
        #1 chk("jal_ready_p1", 64'(bus_a.in_ready), 64'd0);
        step();
        chk("jal_pause2", 64'(a_pause), 64'd1);
        chk("jal_bubble", 64'(bus_a.out_valid), 64'd0);
        #1 chk("jal_ready_p2", 64'(bus_a.in_ready), 64'd0);
        step();
        chk("jal_pause_end", 64'(a_pause), 64'd0);
        #1 chk("jal_ready_end", 64'(bus_a.in_ready), 64'd1);
        step();
        chk("post_jal_valid", 64'(bus_a.out_valid), 64'd1);
        chk("post_jal_inst",  64'(bus_a.out_inst), 64'(I_ADDI));

        // Back-pressure: hold, then flush with out_ready still low
        bus_a.out_ready = 1'b0; bus_a.inst = I_ADD3; bus_a.inst_addr = 32'h208;
        #1 chk("hold_ready", 64'(bus_a.in_ready), 64'd0);
        step();
        chk("hold1_valid", 64'(bus_a.out_valid), 64'd1);
        chk("hold1_inst",  64'(bus_a.out_inst), 64'(I_ADDI));
        chk("hold1_pc",    64'(bus_a.out_inst_addr), 64'h204);
        step();
        chk("hold2_op2",   64'(bus_a.out_operand2), 64'hFFFF_FFFB);
        a_flush = 1'b1;
        #1 chk("flush_ready", 64'(bus_a.in_ready), 64'd0);
        step();
        chk("flush_kill", 64'(bus_a.out_valid), 64'd0);
        a_flush = 1'b0; bus_a.out_ready = 1'b1;

        // Flush clears an active pause
        bus_a.inst = I_JAL; bus_a.inst_addr = 32'h300;
        step();
        chk("fp_pause_on", 64'(a_pause), 64'd1);
        bus_a.in_valid = 1'b0; a_flush = 1'b1;
        step();
        chk("fp_pause_off", 64'(a_pause), 64'd0);
        chk("fp_valid",     64'(bus_a.out_valid), 64'd0);
        a_flush = 1'b0;
        #1 chk("fp_ready", 64'(bus_a.in_ready), 64'd1);

        // 64-bit, no forwarding: LUI x7,0x80000
        bus_b.in_valid = 1'b1; bus_b.inst = I_LUI; bus_b.inst_addr = 64'h400;
        #1 chk("lui_raddr1", 64'(b_addr1), 64'd0);
        step();
        chk("lui_valid", 64'(bus_b.out_valid), 64'd1);
        chk("lui_op1",   bus_b.out_operand1, 64'd0);
        chk("lui_op2",   bus_b.out_operand2, 64'hFFFF_FFFF_8000_0000);
        chk("lui_rd",    64'(bus_b.out_rd), 64'd7);
        bus_b.inst = I_ADDI;
        step();
        chk("addi64_op2", bus_b.out_operand2, 64'hFFFF_FFFF_FFFF_FFFB);

        // FWD_EN=0: MEM writing rs2 stalls instead of forwarding
        bus_b.inst = I_ADD3; b_mem_wb = 1; b_mem_rd = 2; b_mem_data = 64'h22;
        #1 chk("nofwd_ready0", 64'(bus_b.in_ready), 64'd0);
        step();
        chk("nofwd_bubble", 64'(bus_b.out_valid), 64'd0);
        b_mem_wb = 0;
        #1 chk("nofwd_ready1", 64'(bus_b.in_ready), 64'd1);
        step();
        chk("nofwd_op1", bus_b.out_operand1, 64'hB000_0000_0000_0001);
        chk("nofwd_op2", bus_b.out_operand2, 64'hB000_0000_0000_0002);

        // Reset mid-pause, then immediate accept after release
        bus_b.inst = I_JAL; bus_b.inst_addr = 64'h500;
        step();
        chk("b_pause_on", 64'(b_pause), 64'd1);
        bus_b.inst = I_ADDI;
        step();
        chk("b_pause_still", 64'(b_pause), 64'd1);
        rst_b = 1'b1;
        step();
        chk("b_rst_pause", 64'(b_pause), 64'd0);
        chk("b_rst_valid", 64'(bus_b.out_valid), 64'd0);
        rst_b = 1'b0;
        #1 chk("b_rst_ready", 64'(bus_b.in_ready), 64'd1);
        step();
        chk("b_post_rst_valid", 64'(bus_b.out_valid), 64'd1);
        chk("b_post_rst_op2",   bus_b.out_operand2, 64'hFFFF_FFFF_FFFF_FFFB);
        bus_b.in_valid = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
